envelope_generator: RTL and testbench
=====================================

ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

Interface
REQ-001 Parameter ENVELOPE_LEN, default 4: number of envelope stages per oscillator.
REQ-002 Parameter RESET_BIT, default 0: cmds bit index that triggers the envelope.
REQ-003 Parameter GATE_BIT, default 1: cmds bit index that holds a note (key down).
REQ-004 sample_clk  input  1  sole clock, 48 kHz sample rate; one envelope step per rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 envelopes  input  16*ENVELOPE_LEN  packed stage table, entry j: rate = bits [16j+7:16j] (signed two's complement), duration = bits [16j+15:16j+8] (unsigned).
REQ-007 cmds  input  8  command bits from the control unit for this oscillator.
REQ-008 velocity  input  32  note velocity; only bits [15:0] are used, unsigned.
REQ-009 gain  output  16  registered amplitude scaled by velocity, fed to the wave generator.
REQ-010 active  output  1  high while the envelope is running or holding.
REQ-011 stage  output  $clog2(ENVELOPE_LEN)  index of the current stage, for debug.

Function
REQ-012 States SHALL be IDLE, RUN and HOLD; internal amplitude amp is 16-bit unsigned; dcnt is the 8-bit duration counter.
REQ-013 Trigger SHALL be the rising edge of cmds[RESET_BIT], detected against a registered copy of that bit; a bit held high re-triggers only after a low.
REQ-014 On trigger, in any state, the block SHALL set amp=0, stage=0, and enter RUN with dcnt=duration[0], or HOLD if duration[0]==0, on the next edge.
REQ-015 Stage entry SHALL take the stage table values as sampled in the entry cycle; a table change mid-stage affects rate immediately and duration only at the next stage entry.
REQ-016 In RUN, each cycle SHALL update amp to sat(amp + sext(rate)*256), saturating to [0, 65535], and decrement dcnt.
REQ-017 In RUN with dcnt==1, the block SHALL apply the last step and advance to stage+1, so a stage with duration D applies exactly D steps.
REQ-018 Duration 0 SHALL mean HOLD: amp is held constant for as long as cmds[GATE_BIT]==1; when cmds[GATE_BIT]==0, the block advances to stage+1 on the next edge.
REQ-019 Advancing past stage ENVELOPE_LEN-1 SHALL enter IDLE with amp=0 and stage=0.
REQ-020 In IDLE, amp SHALL remain 0 and no table entry is read.
REQ-021 A trigger SHALL take priority over a simultaneous stage completion or gate release.
REQ-022 gain SHALL equal (amp * velocity[15:0]) >> 16 from a single 32-bit product, registered, so gain lags amp by one cycle.
REQ-023 active SHALL be high when state is RUN or HOLD and is registered together with state (no extra latency).
REQ-024 The wrap-around of amp SHALL never occur; saturation at both ends is mandatory.

Reset
REQ-025 While rstn==0, the block SHALL force state=IDLE, amp=0, dcnt=0, stage=0, gain=0, active=0, and the trigger-edge register=0, asynchronously.
REQ-026 After rstn deasserts, a cmds[RESET_BIT] level already high SHALL count as a rising edge on the first clock.
REQ-027 Reset asserted mid-envelope SHALL abort the envelope, with no completion of the current stage.

Verification
REQ-028 Stage table {r0=+16,d0=4; r1=0,d1=0; r2=-16,d2=4; r3=0,d3=1}, velocity=0xFFFF, trigger with gate=1 -> amp steps 4096, 8192, 12288, 16384; HOLD at 16384 until gate=0; then 12288 down to 0; then IDLE; active high throughout; gain follows amp*0xFFFF>>16 one cycle later.
REQ-029 Rate +127, duration 255 -> amp saturates at 65535 and stays there with no wrap; rate -128 from amp=1000 -> amp=0 after one step.
REQ-030 Re-trigger during stage 2 RUN with dcnt==1 -> next edge amp=0, stage=0, RUN; the stage advance is discarded.
REQ-031 rstn pulsed low during HOLD -> gain=0 and active=0 immediately, with no clock needed; after release, with cmds[RESET_BIT]=1, the envelope starts on the first clock.
REQ-032 velocity=0x8000, amp reaching 65535 -> gain=0x7FFF; velocity bits [31:16] set to arbitrary values -> gain unchanged.

Source files
------------

// File: rtl/envelope_generator.sv
// Per-oscillator envelope generator: walks a packed stage table of (rate, duration) pairs and
// produces a velocity-scaled gain one sample after the internal amplitude.
module envelope_generator #(
  parameter int unsigned ENVELOPE_LEN = 4,
  parameter int unsigned RESET_BIT    = 0,
  parameter int unsigned GATE_BIT     = 1
) (
  input  logic                            sample_clk,
  input  logic                            rstn,
  input  logic [16*ENVELOPE_LEN-1:0]      envelopes,
  input  logic [7:0]                      cmds,
  input  logic [31:0]                     velocity,
  output logic [15:0]                     gain,
  output logic                            active,
  output logic [$clog2(ENVELOPE_LEN)-1:0] stage
);

  localparam int unsigned SW = $clog2(ENVELOPE_LEN);
  localparam logic [SW-1:0] LastStage = SW'(ENVELOPE_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e              r_state, w_state_d;
  logic [15:0]         r_amp, w_amp_d;
  logic [7:0]          r_dcnt, w_dcnt_d;
  logic [SW-1:0]       r_stage, w_stage_d;
  logic [15:0]         r_gain, w_gain_d;
  logic                r_active, w_active_d;
  logic                r_trig_q;

  logic [7:0]          w_rate_tab [ENVELOPE_LEN];
  logic [7:0]          w_dur_tab  [ENVELOPE_LEN];
  logic                w_trig, w_gate, w_adv;
  logic [7:0]          w_rate, w_dur_nx;
  logic [SW-1:0]       w_stage_nx;
  logic signed [17:0]  w_sum;
  logic [15:0]         w_amp_sat;
  logic [31:0]         w_prod;
  logic                w_unused_bits;

  for (genvar j = 0; j < ENVELOPE_LEN; j++) begin : g_tab
    assign w_rate_tab[j] = envelopes[16*j +: 8];
    assign w_dur_tab[j]  = envelopes[16*j+8 +: 8];
  end

  assign w_trig     = cmds[RESET_BIT] & ~r_trig_q;
  assign w_gate     = cmds[GATE_BIT];
  assign w_rate     = w_rate_tab[r_stage];
  assign w_stage_nx = r_stage + SW'(1);
  assign w_dur_nx   = w_dur_tab[w_stage_nx];

  // 18-bit signed sum covers amp + rate*256 over the full range, so both ends can clamp
  assign w_sum = $signed({2'b00, r_amp}) + $signed({{2{w_rate[7]}}, w_rate, 8'h00});

  always_comb begin : p_sat
    if (w_sum[17]) begin
      w_amp_sat = 16'h0000;
    end else if (w_sum[16]) begin
      w_amp_sat = 16'hFFFF;
    end else begin
      w_amp_sat = w_sum[15:0];
    end
  end

  assign w_unused_bits = ^{velocity[31:16], cmds};

  always_ff @(posedge sample_clk or negedge rstn) begin : p_state_reg
    if (!rstn) begin
      r_state  <= StIdle;
      r_amp    <= '0;
      r_dcnt   <= '0;
      r_stage  <= '0;
      r_gain   <= '0;
      r_active <= 1'b0;
      r_trig_q <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_amp    <= w_amp_d;
      r_dcnt   <= w_dcnt_d;
      r_stage  <= w_stage_d;
      r_gain   <= w_gain_d;
      r_active <= w_active_d;
      r_trig_q <= cmds[RESET_BIT];
    end
  end

  always_comb begin : p_next
    w_state_d = r_state;
    w_amp_d   = r_amp;
    w_dcnt_d  = r_dcnt;
    w_stage_d = r_stage;
    w_adv     = 1'b0;
    if (w_trig) begin
      w_amp_d   = '0;
      w_stage_d = '0;
      if (w_dur_tab[0] == 8'd0) begin
        w_state_d = StHold;
        w_dcnt_d  = '0;
      end else begin
        w_state_d = StRun;
        w_dcnt_d  = w_dur_tab[0];
      end
    end else begin
      case (r_state)
        StRun: begin
          w_amp_d  = w_amp_sat;
          w_dcnt_d = r_dcnt - 8'd1;
          w_adv    = (r_dcnt == 8'd1);
        end
        StHold:  w_adv = ~w_gate;
        default: w_amp_d = '0;
      endcase
      if (w_adv) begin
        if (r_stage == LastStage) begin
          w_state_d = StIdle;
          w_amp_d   = '0;
          w_stage_d = '0;
          w_dcnt_d  = '0;
        end else begin
          w_stage_d = w_stage_nx;
          if (w_dur_nx == 8'd0) begin
            w_state_d = StHold;
            w_dcnt_d  = '0;
          end else begin
            w_state_d = StRun;
            w_dcnt_d  = w_dur_nx;
          end
        end
      end
    end
  end

  always_comb begin : p_out
    w_active_d = (w_state_d != StIdle);
    w_prod     = r_amp * velocity[15:0];
    w_gain_d   = w_prod[31:16];
  end

  assign gain   = r_gain;
  assign active = r_active;
  assign stage  = r_stage;

endmodule

// File: tb/tb_envelope_generator.sv
// Randomized bench for envelope_generator against a cycle-level integer reference model,
// preceded by directed sequences for ramp/hold, saturation, re-trigger and async reset.
module tb_envelope_generator;

  localparam int LEN = 4;

  logic              sample_clk = 1'b0;
  logic              rstn;
  logic [16*LEN-1:0] envelopes;
  logic [7:0]        cmds;
  logic [31:0]       velocity;
  logic [15:0]       gain;
  logic              active;
  logic [1:0]        stage;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: mode 0 idle, 1 ramping, 2 holding
  int m_amp, m_stage, m_left, m_mode, m_gain;
  bit m_prev;

  always #5 sample_clk = ~sample_clk;

  envelope_generator #(
    .ENVELOPE_LEN(LEN),
    .RESET_BIT   (0),
    .GATE_BIT    (1)
  ) dut (
    .sample_clk(sample_clk),
    .rstn      (rstn),
    .envelopes (envelopes),
    .cmds      (cmds),
    .velocity  (velocity),
    .gain      (gain),
    .active    (active),
    .stage     (stage)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack(input int rate, input int dur);
    return {dur[7:0], rate[7:0]};
  endfunction

  function automatic int m_rate(input int j);
    logic signed [7:0] b;
    b = envelopes[16*j +: 8];
    return int'(b);
  endfunction

  function automatic int m_dur(input int j);
    logic [7:0] d;
    d = envelopes[16*j+8 +: 8];
    return int'(d);
  endfunction

  task automatic model_reset();
    m_amp = 0; m_stage = 0; m_left = 0; m_mode = 0; m_gain = 0; m_prev = 1'b0;
  endtask

  task automatic model_enter(input int s);
    int d;
    d = m_dur(s);
    if (d == 0) m_mode = 2;
    else begin
      m_mode = 1;
      m_left = d;
    end
  endtask

  task automatic model_advance();
    m_stage++;
    if (m_stage == LEN) begin
      m_mode = 0; m_amp = 0; m_stage = 0;
    end else begin
      model_enter(m_stage);
    end
  endtask

  task automatic model_step();
    bit trig;
    trig   = cmds[0] && !m_prev;
    m_prev = cmds[0];
    m_gain = int'((longint'(m_amp) * longint'(velocity[15:0])) >> 16);
    if (trig) begin
      m_amp = 0; m_stage = 0;
      model_enter(0);
    end else if (m_mode == 1) begin
      m_amp = m_amp + m_rate(m_stage) * 256;
      if (m_amp < 0) m_amp = 0;
      if (m_amp > 65535) m_amp = 65535;
      m_left--;
      if (m_left == 0) model_advance();
    end else if (m_mode == 2 && !cmds[1]) begin
      model_advance();
    end
  endtask

  task automatic cycle();
    @(posedge sample_clk);
    #1;
    model_step();
    check("gain", gain, m_gain);
    check("active", active, (m_mode != 0));
    check("stage", stage, m_stage);
  endtask

  function automatic logic [16*LEN-1:0] rand_table();
    logic [16*LEN-1:0] t;
    int d;
    for (int j = 0; j < LEN; j++) begin
      d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
      t[16*j +: 16] = pack(int'($urandom_range(0, 255)), d);
    end
    return t;
  endfunction

  initial begin
    envelopes = {pack(0, 1), pack(-16, 4), pack(0, 0), pack(16, 4)};
    cmds      = 8'h00;
    velocity  = 32'h0000_FFFF;
    rstn      = 1'b0;
    model_reset();
    #12;
    check("rst_gain", gain, 0);
    check("rst_active", active, 0);
    check("rst_stage", stage, 0);
    rstn = 1'b1;
    cycle();

    // ramp up, hold, ramp down, idle
    cmds = 8'h03;
    cycle();
    cmds = 8'h02;
    repeat (4) cycle();
    check("hold_stage", stage, 1);
    cycle();
    check("hold_gain", gain, 16383);
    repeat (5) cycle();
    cmds = 8'h00;
    repeat (6) cycle();
    check("idle_after", active, 0);
    repeat (2) cycle();

    // re-trigger while stage 2 is on its last step
    cmds = 8'h03;
    cycle();
    cmds = 8'h02;
    repeat (6) cycle();
    cmds = 8'h00;
    repeat (4) cycle();
    cmds = 8'h01;
    cycle();
    check("retrig_stage", stage, 0);
    check("retrig_active", active, 1);
    cmds = 8'h00;
    cycle();
    check("retrig_gain", gain, 0);
    repeat (15) cycle();

    // saturation at both ends, then hold at full scale
    envelopes = {pack(0, 0), pack(127, 255), pack(-128, 2), pack(127, 3)};
    cmds = 8'h03;
    cycle();
    cmds = 8'h02;
    repeat (6) cycle();
    check("sat_lo_gain", gain, 0);
    repeat (256) cycle();
    check("sat_hi_gain", gain, 16'hFFFE);
    check("sat_stage", stage, 3);
    velocity = {16'($urandom), 16'h8000};
    cycle();
    check("vel_half", gain, 16'h7FFF);
    velocity = {16'($urandom), 16'h8000};
    cycle();
    check("vel_upper_ignored", gain, 16'h7FFF);

    // asynchronous reset during hold, restart with trigger level already high
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_gain", gain, 0);
    check("async_rst_active", active, 0);
    check("async_rst_stage", stage, 0);
    model_reset();
    cmds = 8'h03;
    #1;
    rstn = 1'b1;
    cycle();
    check("rst_start_active", active, 1);
    cmds = 8'h02;
    repeat (10) cycle();

    velocity = $urandom;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) envelopes = rand_table();
      if ($urandom_range(0, 99) < 10) cmds[1] = ~cmds[1];
      cmds[0]   = ($urandom_range(0, 99) < 6);
      cmds[7:2] = 6'($urandom);
      if ($urandom_range(0, 49) == 0) velocity = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        rstn = 1'b0;
        #1;
        check("rnd_rst_gain", gain, 0);
        check("rnd_rst_active", active, 0);
        model_reset();
        #1;
        rstn = 1'b1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
